aes_block_serializer: RTL and testbench

Output-side bridge between the AES_top encryption pipeline and the UART transmitter. Captures 128-bit cipher blocks, which can arrive one per clock on enc_out_valid/cipher_text_out, into a small block FIFO. Each block is serialized MSB-byte-first as 16 bytes on a valid/ready byte stream to the UART TX. This is the counterpart of the UART-to-AES block assembler on the input side.

---
 rtl/aes_uart_pkg.sv | 21 ++
 rtl/aes_block_serializer_blk_fifo.sv | 72 +++++++
 rtl/aes_block_serializer.sv | 138 +++++++++++++
 tb/tb_aes_block_serializer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_uart_pkg
// Description : Shared constants and types for the AES <-> UART bridge blocks
// Revision    : 1.0  initial release
// ============================================================================
package aes_uart_pkg;

  localparam int BLOCK_W         = 128;
  localparam int BYTE_W          = 8;
  localparam int BYTES_PER_BLOCK = BLOCK_W / BYTE_W;
  localparam int BYTE_CNT_W      = $clog2(BYTES_PER_BLOCK);

  // Serializer FSM encoding
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

endpackage
`default_nettype wire

// File: rtl/aes_block_serializer_blk_fifo.sv
`default_nettype none
// ============================================================================
// Module      : blk_fifo
// Description : Synchronous block FIFO; a push into a full FIFO is accepted
//               when a pop happens on the same edge. Pop must only be
//               requested while count is non-zero.
// Revision    : 1.0  initial release
// ============================================================================
module blk_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             push_ok,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // Accept a write when there is room, or when the head leaves on this edge
  assign push_ok = push && ((count_q != CNT_W'(DEPTH)) || pop);

  // Next pointer and occupancy; pointers wrap naturally at DEPTH (power of 2)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates all reads
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head       = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign count_next = count_d;

endmodule
`default_nettype wire

// File: rtl/aes_block_serializer.sv
`default_nettype none
// ============================================================================
// Module      : aes_block_serializer
// Description : Queues 128-bit cipher blocks and streams each one out
//               MSB-byte-first on a valid/ready byte interface.
// Revision    : 1.0  initial release
// ============================================================================
module aes_block_serializer
  import aes_uart_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               blk_valid,
  input  logic [BLOCK_W-1:0] blk_data,
  output logic               tx_valid,
  output logic [BYTE_W-1:0]  tx_data,
  input  logic               tx_ready,
  input  logic               ovf_clr,
  output logic               overflow,
  output logic [CNT_W-1:0]   fifo_count,
  output logic               busy
);

  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_BLOCK - 1);

  ser_state_e              state_q, state_d;
  logic [BLOCK_W-1:0]      shift_q, shift_d;     // bytes still to send, top-aligned
  logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic                    tx_valid_q, tx_valid_d;
  logic [BYTE_W-1:0]       tx_data_q, tx_data_d;
  logic                    overflow_q, overflow_d;
  logic                    busy_q, busy_d;

  logic                    pop;
  logic                    push_ok;
  logic [BLOCK_W-1:0]      head;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        count_next;
  logic                    handshake;

  blk_fifo #(
    .WIDTH (BLOCK_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (blk_valid),
    .push_data  (blk_data),
    .pop        (pop),
    .push_ok    (push_ok),
    .head       (head),
    .count      (count),
    .count_next (count_next)
  );

  assign handshake = tx_valid_q && tx_ready;

  // Serializer next-state: load a block, step bytes on handshake, chain blocks
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          tx_data_d  = head[BLOCK_W-1 -: BYTE_W];
          shift_d    = head << BYTE_W;
          byte_cnt_d = '0;
          tx_valid_d = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (handshake) begin
          if (byte_cnt_q != LAST_BYTE) begin
            tx_data_d  = shift_q[BLOCK_W-1 -: BYTE_W];
            shift_d    = shift_q << BYTE_W;
            byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
          end else if (count != '0) begin
            pop        = 1'b1;
            tx_data_d  = head[BLOCK_W-1 -: BYTE_W];
            shift_d    = head << BYTE_W;
            byte_cnt_d = '0;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky drop flag (a drop beats a same-edge clear) and registered busy
  always_comb begin
    overflow_d = overflow_q;
    if (ovf_clr)               overflow_d = 1'b0;
    if (blk_valid && !push_ok) overflow_d = 1'b1;
    busy_d = (state_d == SEND) || (count_next != '0);
  end

  // FSM and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign overflow   = overflow_q;
  assign fifo_count = count;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_block_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_block_serializer
// Description : Directed self-checking bench for aes_block_serializer
// Revision    : 1.0  initial release
// ============================================================================
module tb_aes_block_serializer;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             blk_valid = 1'b0;
  logic [127:0]     blk_data = '0;
  logic             tx_ready = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             tx_valid;
  logic [7:0]       tx_data;
  logic             overflow;
  logic [CNT_W-1:0] fifo_count;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0]   rx[$];
  logic [127:0] exp_blk[$];

  logic [127:0] cipher [6] = '{
    128'h69c4e0d86a7b0430d8cdb78070b4c55a,
    128'hc35244a00f8e1a2b3c4d5e6f8090a078,
    128'h07fe112233445566778899aabbccdd93,
    128'h3c44f0e1d2c3b4a5968778695a4b3c13,
    128'h00112233445566778899aabbccddeeff,
    128'hdeadbeefcafef00d0123456789abcdef
  };

  aes_block_serializer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .blk_valid  (blk_valid),
    .blk_data   (blk_data),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .ovf_clr    (ovf_clr),
    .overflow   (overflow),
    .fifo_count (fifo_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Inputs only change just after a rising edge, so the falling-edge view
  // is exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) rx.push_back(tx_data);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_blk(input logic [127:0] d);
    blk_valid = 1'b1;
    blk_data  = d;
    tick();
    blk_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int n, input int budget);
    int cyc = 0;
    while ((rx.size() < n || tx_valid || busy) && cyc < budget) begin
      tick();
      cyc++;
    end
    check({name, "_drain_timeout"}, (cyc < budget), 1);
  endtask

  task automatic check_stream(input string name);
    logic [127:0] b;
    logic [7:0]   e;
    check({name, "_len"}, rx.size(), exp_blk.size() * 16);
    for (int i = 0; i < rx.size() && i < exp_blk.size() * 16; i++) begin
      b = exp_blk[i / 16];
      e = b[127 - 8 * (i % 16) -: 8];
      check($sformatf("%s_byte%0d", name, i), rx[i], e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           peak;
    logic         prev_v, prev_r;
    logic [7:0]   prev_d;
    logic [127:0] b;

    // Reset state
    #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_busy", busy, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 1: single block, tx_ready held high
    rx.delete();
    exp_blk = '{cipher[0]};
    tx_ready = 1'b1;
    push_blk(cipher[0]);
    check("t1_valid_k", tx_valid, 0);
    check("t1_count_k", fifo_count, 1);
    check("t1_busy_k", busy, 1);
    tick();
    check("t1_valid_k1", tx_valid, 1);
    check("t1_data_k1", tx_data, 8'h69);
    check("t1_count_k1", fifo_count, 0);
    repeat (16) tick();
    check("t1_nbytes", rx.size(), 16);
    check("t1_valid_end", tx_valid, 0);
    check("t1_busy_end", busy, 0);
    check("t1_overflow", overflow, 0);
    check_stream("t1");

    // 2: four back-to-back blocks, no gaps
    rx.delete();
    exp_blk = '{cipher[0], cipher[1], cipher[2], cipher[3]};
    peak = 0;
    for (int i = 0; i < 4; i++) begin
      blk_valid = 1'b1;
      blk_data  = cipher[i];
      tick();
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    blk_valid = 1'b0;
    for (int i = 0; i < 62; i++) begin
      tick();
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    check("t2_peak", peak, 3);
    check("t2_valid_end", tx_valid, 0);
    check_stream("t2");
    if (rx.size() == 64) begin
      check("t2_byte16", rx[16], 8'hc3);
      check("t2_byte63", rx[63], 8'h13);
    end

    // 3: overflow with tx_ready low
    rx.delete();
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_blk(cipher[i]);
    check("t3_count", fifo_count, 4);
    check("t3_valid", tx_valid, 1);
    check("t3_data", tx_data, 8'h69);
    check("t3_overflow", overflow, 1);
    tx_ready = 1'b1;
    exp_blk = '{cipher[0], cipher[1], cipher[2], cipher[3], cipher[4]};
    drain("t3", 80, 200);
    check_stream("t3");
    check("t3_ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t3_ovf_clr", overflow, 0);

    // 4: backpressure pattern 1,0,0,1,0,0,...
    rx.delete();
    exp_blk = '{cipher[1]};
    tx_ready = 1'b0;
    push_blk(cipher[1]);
    tick();
    for (int cyc = 0; cyc < 100 && !(rx.size() == 16 && !tx_valid); cyc++) begin
      tx_ready = (cyc % 3 == 0);
      prev_v = tx_valid;
      prev_d = tx_data;
      prev_r = tx_ready;
      tick();
      if (prev_v && !prev_r) begin
        check("t4_hold_valid", tx_valid, 1);
        check("t4_hold_data", tx_data, prev_d);
      end
    end
    tx_ready = 1'b1;
    check("t4_done", (rx.size() == 16 && !tx_valid), 1);
    check_stream("t4");

    // 5: write into a full FIFO on the final-byte handshake
    rx.delete();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_blk(cipher[i]);
    check("t5_count_full", fifo_count, 4);
    tx_ready = 1'b1;
    repeat (15) tick();
    blk_valid = 1'b1;
    blk_data  = cipher[5];
    tick();
    blk_valid = 1'b0;
    check("t5_overflow", overflow, 0);
    check("t5_count", fifo_count, 4);
    check("t5_valid", tx_valid, 1);
    check("t5_next_byte", tx_data, 8'hc3);
    exp_blk = '{cipher[0], cipher[1], cipher[2], cipher[3], cipher[4], cipher[5]};
    drain("t5", 96, 300);
    check_stream("t5");

    // 6: asynchronous reset mid-block
    rx.delete();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_blk(cipher[i]);
    tx_ready = 1'b1;
    repeat (7) tick();
    b = cipher[0];
    check("t6_byte7", tx_data, b[127-56 -: 8]);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", tx_valid, 0);
    check("t6_rst_count", fifo_count, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_data", tx_data, 0);
    tick();
    rst = 1'b0;
    rx.delete();
    exp_blk = '{cipher[3]};
    push_blk(cipher[3]);
    drain("t6", 16, 100);
    check_stream("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
